// File: rtl/platform_pio_displays_hex.sv
// platform_pio_displays_hex: Avalon-MM hex seven-segment controller with per-digit enable, blank and blink.
// Define PIO_DISPLAYS_BLINK_EN to build the blink counter, phase, blink mask and BLINK_DIV register.
module platform_pio_displays_hex #(
    parameter int          N_DIGITS        = 4,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1,
    parameter logic [31:0] BLINK_DIV_RESET = 32'd25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*N_DIGITS-1:0]   out_port
);
    localparam int DW = 4*N_DIGITS;
    localparam logic [7*N_DIGITS-1:0] SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic                  wr_en;
    logic [DW-1:0]         data;
    logic [N_DIGITS-1:0]   en_mask;
    logic [N_DIGITS-1:0]   blink_mask;
    logic                  blank;
    logic                  phase;
    logic [31:0]           div_rd;
    logic [7*N_DIGITS-1:0] seg_next;
    assign wr_en = chipselect & ~write_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            en_mask <= '1;
            blank   <= 1'b0;
        end else if (wr_en) begin
            if (address == 2'd0) data <= writedata[DW-1:0];
            if (address == 2'd1) begin
                en_mask <= writedata[N_DIGITS-1:0];
                blank   <= writedata[16];
            end
        end
    end
`ifdef PIO_DISPLAYS_BLINK_EN
    logic [31:0] blink_div;
    logic [31:0] cnt;
    logic        wrap;
    assign wrap   = (blink_div != 32'd0) && (cnt == blink_div - 32'd1);
    assign div_rd = blink_div;
    // A BLINK_DIV write restarts the count but a coincident wrap still toggles phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_mask <= '0;
            blink_div  <= BLINK_DIV_RESET;
            cnt        <= '0;
            phase      <= 1'b0;
        end else begin
            if (wr_en && address == 2'd1) blink_mask <= writedata[8 +: N_DIGITS];
            if (wr_en && address == 2'd2) blink_div <= writedata;
            cnt   <= (blink_div == 32'd0 || wrap || (wr_en && address == 2'd2)) ? 32'd0 : cnt + 32'd1;
            phase <= (blink_div == 32'd0) ? 1'b0 : phase ^ wrap;
        end
    end
`else
    logic unused_wd;
    assign blink_mask = '0;
    assign phase      = 1'b0;
    assign div_rd     = 32'd0;
    assign unused_wd  = ^writedata;
`endif
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < N_DIGITS; i++)
            seg_next[7*i +: 7] = (en_mask[i] && !blank && !(blink_mask[i] && phase)) ? GLYPH[data[4*i +: 4]] : 7'h00;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_port <= SEG_OFF;
        else       out_port <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
    end
    always_comb begin
        readdata = address == 2'd0 ? 32'(data) :
                   address == 2'd1 ? {15'd0, blank, 8'(blink_mask), 8'(en_mask)} :
                   address == 2'd2 ? div_rd : {31'd0, phase};
    end
endmodule

// File: tb/tb_platform_pio_displays_hex.sv
// tb_platform_pio_displays_hex: directed self-checking bench, N_DIGITS=4, active-low segments.
module tb_platform_pio_displays_hex;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [27:0] out_port;
    int checks = 0;
    int errors = 0;
    localparam logic [6:0] G3 = 7'h30, GF = 7'h0E, G5 = 7'h12, GA = 7'h08, OFF = 7'h7F, Z = 7'h40;
    always #5 clk = ~clk;
    platform_pio_displays_hex #(.N_DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .BLINK_DIV_RESET(32'd100)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask
    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1 check(tag, readdata, exp);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_port), 32'h0FFFFFFF);
        rd("rst_data", 2'd0, 32'd0);
        rd("rst_ctrl", 2'd1, 32'h0000000F);
`ifdef PIO_DISPLAYS_BLINK_EN
        rd("rst_div", 2'd2, 32'd100);
`else
        rd("rst_div", 2'd2, 32'd0);
`endif
        rd("rst_status", 2'd3, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_zero", 32'(out_port), 32'({Z, Z, Z, Z}));
        wr(2'd0, 32'h0000A5F3);
        @(negedge clk);
        check("data_glyph", 32'(out_port), 32'({GA, G5, GF, G3}));
        rd("data_rb", 2'd0, 32'h0000A5F3);
        wr(2'd0, 32'hFFFFFFFF);
        rd("data_trunc", 2'd0, 32'h0000FFFF);
        @(negedge clk);
        check("all_f", 32'(out_port), 32'({GF, GF, GF, GF}));
        wr(2'd0, 32'h0000A5F3);
`ifdef PIO_DISPLAYS_BLINK_EN
        wr(2'd2, 32'd4);
        wr(2'd1, 32'h0000020F);
        rd("ctrl_rb", 2'd1, 32'h0000020F);
        for (int n = 1; n <= 12; n++) begin
            rd("blink_status", 2'd3, 32'((n >> 2) & 1));
            check("blink_out", 32'(out_port), 32'({GA, G5, (((n - 1) >> 2) & 1) != 0 ? OFF : GF, G3}));
            @(negedge clk);
        end
        wr(2'd2, 32'd0);
        rd("div0_hold", 2'd3, 32'd1);
        @(negedge clk);
        rd("div0_clear", 2'd3, 32'd0);
        check("div0_lag", 32'(out_port), 32'({GA, G5, OFF, G3}));
        @(negedge clk);
        check("div0_lit", 32'(out_port), 32'({GA, G5, GF, G3}));
        repeat (4) @(negedge clk);
        rd("div0_steady", 2'd3, 32'd0);
        check("div0_steady_out", 32'(out_port), 32'({GA, G5, GF, G3}));
        wr(2'd2, 32'd3);
        rd("div3_rb", 2'd2, 32'd3);
        repeat (2) @(negedge clk);
        rd("div3_before", 2'd3, 32'd0);
        @(negedge clk);
        rd("div3_toggle", 2'd3, 32'd1);
        wr(2'd2, 32'd0);
`else
        wr(2'd2, 32'd5);
        wr(2'd1, 32'h0000FF0F);
        rd("nb_div", 2'd2, 32'd0);
        rd("nb_ctrl", 2'd1, 32'h0000000F);
        for (int n = 1; n <= 12; n++) begin
            rd("nb_status", 2'd3, 32'd0);
            check("nb_out", 32'(out_port), 32'({GA, G5, GF, G3}));
            @(negedge clk);
        end
`endif
        wr(2'd1, 32'h00010000);
        @(negedge clk);
        check("blank_out", 32'(out_port), 32'h0FFFFFFF);
        rd("blank_rb", 2'd1, 32'h00010000);
        wr(2'd1, 32'h0000000A);
        @(negedge clk);
        check("mask_a", 32'(out_port), 32'({GA, OFF, GF, OFF}));
        rd("mask_rb", 2'd1, 32'h0000000A);
        wr(2'd3, 32'h00000001);
        rd("status_ro", 2'd3, 32'd0);
        wr(2'd1, 32'hFFFFFFFF);
`ifdef PIO_DISPLAYS_BLINK_EN
        rd("ctrl_ones", 2'd1, 32'h00010F0F);
`else
        rd("ctrl_ones", 2'd1, 32'h0001000F);
`endif
        @(negedge clk);
        check("ctrl_ones_out", 32'(out_port), 32'h0FFFFFFF);
        wr(2'd1, 32'h0000000F);
        @(negedge clk);
        check("pre_reset", 32'(out_port), 32'({GA, G5, GF, G3}));
        #2 reset = 1'b1;
        #1 check("async_rst_out", 32'(out_port), 32'h0FFFFFFF);
        rd("async_rst_data", 2'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rerelease", 32'(out_port), 32'({Z, Z, Z, Z}));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
